// File: rtl/mem_arb_pkg.sv
// Shared constants for the DRAM port arbiter: FSM state encoding and default sizes.
package mem_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and DRAM-side signal bundle of the port arbiter.
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_rden;
  logic                    mem_wren;
  logic [DATA_W-1:0]       mem_q;

  modport slave (
    input  req, we, addr, wdata, lock, mem_q,
    output gnt, ack, rvalid, rdata, mem_addr, mem_wdata, mem_rden, mem_wren
  );

  modport master (
    output req, we, addr, wdata, lock, mem_q,
    input  gnt, ack, rvalid, rdata, mem_addr, mem_wdata, mem_rden, mem_wren
  );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request scanning upward from ptr, wrapping.
module rr_priority_select #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among N_REQ requesters (IDLE->ACCESS->RESP).
// Define LOCK_EN to let the owner chain back-to-back accesses by holding lock with req in RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          i_clk,
  input logic          i_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     own;
  logic [N_REQ-1:0]  gnt_r;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_hold;

  logic [N_REQ-1:0]  sel_gnt;
  logic [IW-1:0]     sel_idx;
  logic              sel_any;
  logic              relock;

  rr_priority_select #(.N_REQ(N_REQ), .IW(IW)) u_sel (
    .req (bus.req),
    .ptr (ptr),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

`ifdef LOCK_EN
  assign relock = bus.lock[own] & bus.req[own];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign relock      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      own        <= '0;
      gnt_r      <= '0;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            gnt_r   <= sel_gnt;
            own     <= sel_idx;
            we_l    <= bus.we[sel_idx];
            addr_l  <= bus.addr[sel_idx*ADDR_W +: ADDR_W];
            wdata_l <= bus.wdata[sel_idx*DATA_W +: DATA_W];
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Re-assigning own+1 on a locked re-access leaves ptr unchanged.
          ptr   <= (own == IW'(N_REQ - 1)) ? '0 : own + 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!we_l) rdata_hold <= bus.mem_q;
          if (relock) begin
            we_l    <= bus.we[own];
            addr_l  <= bus.addr[own*ADDR_W +: ADDR_W];
            wdata_l <= bus.wdata[own*DATA_W +: DATA_W];
            state   <= ST_ACCESS;
          end else begin
            gnt_r <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- output stage: DRAM strobes in ACCESS, ack/read data in RESP ----
  assign bus.gnt       = gnt_r;
  assign bus.ack       = (state == ST_RESP) ? gnt_r : '0;
  assign bus.rvalid    = (state == ST_RESP && !we_l) ? gnt_r : '0;
  assign bus.rdata     = (state == ST_RESP && !we_l) ? bus.mem_q : rdata_hold;
  assign bus.mem_addr  = addr_l;
  assign bus.mem_wdata = wdata_l;
  assign bus.mem_rden  = (state == ST_ACCESS) && !we_l;
  assign bus.mem_wren  = (state == ST_ACCESS) && we_l;

endmodule
